// File: rtl/dc_cache.sv
`default_nettype none
// ============================================================================
// dc_cache : direct-mapped, write-through, no-write-allocate data cache that
//            sits between the load/store buffer and the memory controller.
// Revision  : 1.0
// ============================================================================
module dc_cache #(
    parameter int         LINE_NUM = 64,
    parameter logic [1:0] IO_SEL   = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        iLSB_En,
    input  logic        iLSB_Rw,
    input  logic [2:0]  iLSB_Len,
    input  logic [31:0] iLSB_Add,
    input  logic [31:0] iLSB_Dat,
    output logic        oLSB_En,
    output logic [31:0] oLSB_Dat,
    output logic        oMC_En,
    output logic        oMC_Rw,
    output logic [2:0]  oMC_Len,
    output logic [31:0] oMC_Add,
    output logic [31:0] oMC_Dat,
    input  logic        iMC_En,
    input  logic [31:0] iMC_Dat,
    input  logic        iROB_Mp
);
    localparam int IDX_W = $clog2(LINE_NUM);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        RD_IO   = 2'd2,
        WR      = 2'd3
    } state_t;

    state_t             r_state, w_state_n;
    logic               r_valid [LINE_NUM];
    logic [TAG_W-1:0]   r_tag   [LINE_NUM];
    logic [31:0]        r_word  [LINE_NUM];

    logic [IDX_W-1:0]   r_idx;
    logic [TAG_W-1:0]   r_rtag;
    logic [1:0]         r_off;
    logic [2:0]         r_len;
    logic               r_kill, r_lsb_en, r_hit_resp;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_io, w_hit, w_rd_req, w_wr_req;
    logic               w_issue, w_mc_rw, w_merge, w_fill, w_resp, w_hit_resp;
    logic [2:0]         w_mc_len;
    logic [31:0]        w_mc_add, w_resp_dat;

    function automatic logic [31:0] len_mask(input logic [2:0] len);
        case (len)
            3'd1:    return 32'h0000_00FF;
            3'd2:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                            input logic [2:0] len);
        return (word >> {off, 3'b000}) & len_mask(len);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] dat,
                                          input logic [1:0] off, input logic [2:0] len);
        logic [31:0] m;
        m = len_mask(len) << {off, 3'b000};
        return (word & ~m) | ((dat << {off, 3'b000}) & m);
    endfunction

    assign w_idx    = iLSB_Add[IDX_W+1:2];
    assign w_tag    = iLSB_Add[31:IDX_W+2];
    assign w_io     = (iLSB_Add[17:16] == IO_SEL);
    assign w_hit    = !w_io && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // Committed stores must never be lost, so they bypass both the flush and the enable.
    assign w_rd_req = en && iLSB_En && !iLSB_Rw && !iROB_Mp;
    assign w_wr_req = (en || iROB_Mp) && iLSB_En && iLSB_Rw;

    always_comb begin
        w_state_n  = r_state;
        w_issue    = 1'b0;
        w_mc_rw    = 1'b0;
        w_mc_len   = iLSB_Len;
        w_mc_add   = iLSB_Add;
        w_merge    = 1'b0;
        w_fill     = 1'b0;
        w_resp     = 1'b0;
        w_hit_resp = 1'b0;
        w_resp_dat = 32'd0;
        case (r_state)
            IDLE: begin
                if (w_wr_req) begin
                    w_issue   = 1'b1;
                    w_mc_rw   = 1'b1;
                    w_merge   = w_hit;
                    w_state_n = WR;
                end else if (w_rd_req) begin
                    if (w_io) begin
                        w_issue   = 1'b1;
                        w_state_n = RD_IO;
                    end else if (w_hit) begin
                        w_resp     = 1'b1;
                        w_hit_resp = 1'b1;
                        w_resp_dat = extract(r_word[w_idx], iLSB_Add[1:0], iLSB_Len);
                    end else begin
                        w_issue   = 1'b1;
                        w_mc_len  = 3'd4;
                        w_mc_add  = {iLSB_Add[31:2], 2'b00};
                        w_state_n = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                if (en && iMC_En) begin
                    w_fill     = 1'b1;
                    w_resp     = !(r_kill || iROB_Mp);
                    w_resp_dat = extract(iMC_Dat, r_off, r_len);
                    w_state_n  = IDLE;
                end
            end
            RD_IO: begin
                if (en && iMC_En) begin
                    w_resp     = !(r_kill || iROB_Mp);
                    w_resp_dat = iMC_Dat;
                    w_state_n  = IDLE;
                end
            end
            WR: begin
                if (en && iMC_En) begin
                    w_resp    = 1'b1;
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_kill     <= 1'b0;
            r_lsb_en   <= 1'b0;
            r_hit_resp <= 1'b0;
            r_idx      <= '0;
            r_rtag     <= '0;
            r_off      <= 2'd0;
            r_len      <= 3'd0;
            oLSB_Dat   <= 32'd0;
            oMC_En     <= 1'b0;
            oMC_Rw     <= 1'b0;
            oMC_Len    <= 3'd0;
            oMC_Add    <= 32'd0;
            oMC_Dat    <= 32'd0;
        end else begin
            r_lsb_en   <= w_resp;
            r_hit_resp <= w_hit_resp;
            oMC_En     <= w_issue;
            r_kill     <= (r_state == RD_MISS || r_state == RD_IO) && (w_state_n != IDLE)
                          && (r_kill || (en && iROB_Mp));
            if (w_issue) begin
                oMC_Rw  <= w_mc_rw;
                oMC_Len <= w_mc_len;
                oMC_Add <= w_mc_add;
                oMC_Dat <= iLSB_Dat;
                r_idx   <= w_idx;
                r_rtag  <= w_tag;
                r_off   <= iLSB_Add[1:0];
                r_len   <= iLSB_Len;
            end
            if (w_resp) oLSB_Dat <= w_resp_dat;
        end
    end

    // A hit response is withdrawn if a flush lands in the cycle it is presented.
    assign oLSB_En = r_lsb_en && !(r_hit_resp && iROB_Mp);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LINE_NUM; i++) r_valid[i] <= 1'b0;
        end else if (w_fill) begin
            r_valid[r_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[r_idx]  <= r_rtag;
            r_word[r_idx] <= iMC_Dat;
        end else if (w_merge) begin
            r_word[w_idx] <= merge(r_word[w_idx], iLSB_Dat, iLSB_Add[1:0], iLSB_Len);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dc_cache.sv
`default_nettype none
// ============================================================================
// tb_dc_cache : directed table, corner sequences and randomized traffic checked
//               against a line/memory reference model.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_dc_cache;
    logic        clk = 1'b0, rst = 1'b0, en = 1'b1;
    logic        iLSB_En = 1'b0, iLSB_Rw = 1'b0;
    logic [2:0]  iLSB_Len = 3'd0;
    logic [31:0] iLSB_Add = 32'd0, iLSB_Dat = 32'd0;
    logic        oLSB_En, oMC_En, oMC_Rw;
    logic [31:0] oLSB_Dat, oMC_Add, oMC_Dat;
    logic [2:0]  oMC_Len;
    logic        iMC_En = 1'b0, iROB_Mp = 1'b0;
    logic [31:0] iMC_Dat = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dc_cache #(.LINE_NUM(64), .IO_SEL(2'b11)) dut (
        .clk(clk), .rst(rst), .en(en),
        .iLSB_En(iLSB_En), .iLSB_Rw(iLSB_Rw), .iLSB_Len(iLSB_Len),
        .iLSB_Add(iLSB_Add), .iLSB_Dat(iLSB_Dat),
        .oLSB_En(oLSB_En), .oLSB_Dat(oLSB_Dat),
        .oMC_En(oMC_En), .oMC_Rw(oMC_Rw), .oMC_Len(oMC_Len),
        .oMC_Add(oMC_Add), .oMC_Dat(oMC_Dat),
        .iMC_En(iMC_En), .iMC_Dat(iMC_Dat), .iROB_Mp(iROB_Mp)
    );

    // reference model: one entry per line plus a word-addressed backing memory
    bit          mv [64];
    logic [23:0] mt [64];
    logic [31:0] mw [64];
    logic [31:0] mem [bit [29:0]];

    typedef struct {
        bit          rw;
        logic [2:0]  len;
        logic [31:0] add;
        logic [31:0] dat;
        logic [31:0] mc_dat;
        bit          exp_mc;
        logic [2:0]  exp_len;
        logic [31:0] exp_add;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vt [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // returns mid-cycle after the edge that captured the request
    task automatic drive_req(input bit rw, input logic [2:0] len, input logic [31:0] add,
                             input logic [31:0] dat, input bit mp);
        @(negedge clk);
        iLSB_En = 1'b1; iLSB_Rw = rw; iLSB_Len = len; iLSB_Add = add; iLSB_Dat = dat;
        iROB_Mp = mp;
        @(negedge clk);
        iLSB_En = 1'b0; iROB_Mp = 1'b0;
        #1;
    endtask

    task automatic mc_reply(input int lat, input bit mp_wait, input logic [31:0] mdat,
                            output bit got, output logic [31:0] gdat);
        for (int k = 0; k < lat; k++) begin
            if (mp_wait && k == 0) iROB_Mp = 1'b1;
            @(negedge clk);
            iROB_Mp = 1'b0;
        end
        iMC_En = 1'b1; iMC_Dat = mdat;
        @(negedge clk);
        iMC_En = 1'b0;
        #1;
        got  = oLSB_En;
        gdat = oLSB_Dat;
    endtask

    function automatic logic [31:0] lmask(input logic [2:0] len);
        if (len == 3'd4) return 32'hFFFF_FFFF;
        return (32'd1 << (8 * len)) - 32'd1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    endtask

    task automatic rand_xact();
        bit          rw, mpq, mpw, io, hit, got;
        int          lat, sh;
        logic [2:0]  len;
        logic [1:0]  off;
        logic [23:0] tagv;
        logic [5:0]  idx;
        logic [29:0] wa;
        logic [31:0] add, dat, mdat, gd, m, nw;
        rw = ($urandom_range(0, 2) == 0);
        case ($urandom_range(0, 2))
            0:       len = 3'd1;
            1:       len = 3'd2;
            default: len = 3'd4;
        endcase
        if (len == 3'd4)      off = 2'd0;
        else if (len == 3'd2) off = 2'(2 * $urandom_range(0, 1));
        else                  off = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 4))
            0:       tagv = 24'h0;
            1:       tagv = 24'h1;
            2:       tagv = 24'h2;
            3:       tagv = 24'h5;
            default: tagv = 24'h300;
        endcase
        add  = {tagv, 6'($urandom_range(0, 3)), off};
        dat  = $urandom;
        mpq  = ($urandom_range(0, 9) == 0);
        mpw  = ($urandom_range(0, 5) == 0);
        lat  = $urandom_range(1, 3);
        io   = (add[17:16] == 2'b11);
        idx  = add[7:2];
        wa   = add[31:2];
        sh   = 8 * int'(off);
        m    = lmask(len);
        hit  = !io && mv[idx] && (mt[idx] == add[31:8]);
        if (!mem.exists(wa)) mem[wa] = $urandom;

        drive_req(rw, len, add, dat, mpq);
        if (!rw && mpq) begin
            check("rnd_mp_drop_mc", 32'(oMC_En), 32'd0);
            check("rnd_mp_drop_lsb", 32'(oLSB_En), 32'd0);
            return;
        end
        if (!rw && hit) begin
            check("rnd_hit_en", 32'(oLSB_En), 32'd1);
            check("rnd_hit_nomc", 32'(oMC_En), 32'd0);
            check("rnd_hit_dat", oLSB_Dat, (mw[idx] >> sh) & m);
            return;
        end
        check("rnd_mc_en", 32'(oMC_En), 32'd1);
        check("rnd_mc_rw", 32'(oMC_Rw), 32'(rw));
        check("rnd_mc_len", 32'(oMC_Len), (rw || io) ? 32'(len) : 32'd4);
        check("rnd_mc_add", oMC_Add, (rw || io) ? add : {add[31:2], 2'b00});
        if (rw) begin
            check("rnd_mc_dat", oMC_Dat, dat);
            nw = (mem[wa] & ~(m << sh)) | ((dat << sh) & (m << sh));
            mem[wa] = nw;
            if (hit) mw[idx] = nw;
            mdat = $urandom;
        end else if (io) begin
            mdat = (mem[wa] >> sh) & m;
        end else begin
            mdat = mem[wa];
        end
        mc_reply(lat, mpw, mdat, got, gd);
        if (!rw && !io) begin
            mv[idx] = 1'b1; mt[idx] = add[31:8]; mw[idx] = mdat;
        end
        check("rnd_ack", 32'(got), (rw || !mpw) ? 32'd1 : 32'd0);
        if (!rw && !mpw) check("rnd_rd_dat", gd, io ? mdat : (mdat >> sh) & m);
    endtask

    initial begin
        bit          got;
        logic [31:0] gd;

        vt[0] = '{0, 3'd4, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1, 3'd4, 32'h0000_0100, 32'hDEAD_BEEF};
        vt[1] = '{0, 3'd4, 32'h0000_0100, 32'h0, 32'h0,         0, 3'd0, 32'h0,         32'hDEAD_BEEF};
        vt[2] = '{0, 3'd1, 32'h0000_0103, 32'h0, 32'h0,         0, 3'd0, 32'h0,         32'h0000_00DE};
        vt[3] = '{1, 3'd2, 32'h0000_0102, 32'h1234, 32'h0,      1, 3'd2, 32'h0000_0102, 32'h0};
        vt[4] = '{0, 3'd4, 32'h0000_0100, 32'h0, 32'h0,         0, 3'd0, 32'h0,         32'h1234_BEEF};
        vt[5] = '{0, 3'd4, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 1, 3'd4, 32'h0000_0200, 32'hCAFE_F00D};
        vt[6] = '{0, 3'd4, 32'h0000_0100, 32'h0, 32'h1234_BEEF, 1, 3'd4, 32'h0000_0100, 32'h1234_BEEF};
        vt[7] = '{0, 3'd1, 32'h0003_0000, 32'h0, 32'h0000_005A, 1, 3'd1, 32'h0003_0000, 32'h0000_005A};
        vt[8] = '{0, 3'd1, 32'h0003_0000, 32'h0, 32'h0000_00A5, 1, 3'd1, 32'h0003_0000, 32'h0000_00A5};
        vt[9] = '{0, 3'd2, 32'h0000_0102, 32'h0, 32'h0,         0, 3'd0, 32'h0,         32'h0000_1234};

        repeat (3) @(negedge clk);
        check("rst_lsb_en", 32'(oLSB_En), 32'd0);
        check("rst_lsb_dat", oLSB_Dat, 32'd0);
        check("rst_mc_en", 32'(oMC_En), 32'd0);
        check("rst_mc_rw", 32'(oMC_Rw), 32'd0);
        check("rst_mc_len", 32'(oMC_Len), 32'd0);
        check("rst_mc_add", oMC_Add, 32'd0);
        check("rst_mc_dat", oMC_Dat, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive_req(vt[i].rw, vt[i].len, vt[i].add, vt[i].dat, 1'b0);
            check($sformatf("vec%0d_mc_en", i), 32'(oMC_En), 32'(vt[i].exp_mc));
            if (vt[i].exp_mc) begin
                check($sformatf("vec%0d_mc_rw", i), 32'(oMC_Rw), 32'(vt[i].rw));
                check($sformatf("vec%0d_mc_len", i), 32'(oMC_Len), 32'(vt[i].exp_len));
                check($sformatf("vec%0d_mc_add", i), oMC_Add, vt[i].exp_add);
                if (vt[i].rw) check($sformatf("vec%0d_mc_dat", i), oMC_Dat, vt[i].dat);
                mc_reply(1, 1'b0, vt[i].mc_dat, got, gd);
                check($sformatf("vec%0d_ack", i), 32'(got), 32'd1);
                if (!vt[i].rw) check($sformatf("vec%0d_rd_dat", i), gd, vt[i].exp_rd);
            end else begin
                check($sformatf("vec%0d_hit_en", i), 32'(oLSB_En), 32'd1);
                check($sformatf("vec%0d_hit_dat", i), oLSB_Dat, vt[i].exp_rd);
            end
        end

        // flush in the cycle a hit response is presented
        @(negedge clk);
        iLSB_En = 1'b1; iLSB_Rw = 1'b0; iLSB_Len = 3'd4; iLSB_Add = 32'h0000_0100;
        @(negedge clk);
        iLSB_En = 1'b0; iROB_Mp = 1'b1;
        #1;
        check("hit_mp_suppress", 32'(oLSB_En), 32'd0);
        check("hit_mp_nomc", 32'(oMC_En), 32'd0);
        @(negedge clk);
        iROB_Mp = 1'b0;

        // flush during a miss: no response, but the line is still filled
        drive_req(1'b0, 3'd4, 32'h0000_0504, 32'h0, 1'b0);
        check("mpmiss_mc_en", 32'(oMC_En), 32'd1);
        mc_reply(2, 1'b1, 32'h0BAD_F00D, got, gd);
        check("mpmiss_no_ack", 32'(got), 32'd0);
        drive_req(1'b0, 3'd4, 32'h0000_0504, 32'h0, 1'b0);
        check("mpmiss_then_hit", 32'(oLSB_En), 32'd1);
        check("mpmiss_hit_dat", oLSB_Dat, 32'h0BAD_F00D);

        // reset in the middle of a miss
        drive_req(1'b0, 3'd4, 32'h0000_0400, 32'h0, 1'b0);
        check("rstmid_mc_en", 32'(oMC_En), 32'd1);
        rst = 1'b0;
        #1;
        check("rstmid_mc_en0", 32'(oMC_En), 32'd0);
        check("rstmid_mc_add0", oMC_Add, 32'd0);
        check("rstmid_lsb_en0", 32'(oLSB_En), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        iMC_En = 1'b1; iMC_Dat = 32'h1111_2222;
        @(negedge clk);
        iMC_En = 1'b0;
        #1;
        check("late_mc_ignored", 32'(oLSB_En), 32'd0);
        drive_req(1'b0, 3'd4, 32'h0000_0100, 32'h0, 1'b0);
        check("postrst_miss", 32'(oMC_En), 32'd1);
        mc_reply(1, 1'b0, 32'h1234_BEEF, got, gd);
        check("postrst_fill", gd, 32'h1234_BEEF);

        // enable low: reads ignored, flushed stores still go out
        en = 1'b0;
        drive_req(1'b0, 3'd4, 32'h0000_0100, 32'h0, 1'b0);
        check("en0_no_hit", 32'(oLSB_En), 32'd0);
        check("en0_no_mc", 32'(oMC_En), 32'd0);
        drive_req(1'b1, 3'd4, 32'h0000_0100, 32'h5555_AAAA, 1'b1);
        check("en0_mpwr_mc_en", 32'(oMC_En), 32'd1);
        check("en0_mpwr_mc_rw", 32'(oMC_Rw), 32'd1);
        en = 1'b1;
        mc_reply(1, 1'b0, 32'h0, got, gd);
        check("en0_mpwr_ack", 32'(got), 32'd1);
        drive_req(1'b0, 3'd4, 32'h0000_0100, 32'h0, 1'b0);
        check("wrhit_merged", oLSB_Dat, 32'h5555_AAAA);

        do_reset();
        for (int it = 0; it < 400; it++) rand_xact();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dc_cache.md
# dc_cache

Parametrised direct-mapped, write-through, no-write-allocate data cache between the load/store buffer (LSB) and the memory controller (MC). It replaces the pass-through data-cache stage: same LSB-side and MC-side request/response signalling, plus a configurable line store that serves read hits in one cycle. It also bypasses the I/O address window and drops load responses killed by a misprediction while letting committed stores complete.

## Interface
- LINE_NUM, 64: number of one-word lines, power of two ≥ 2; IDX_W = log2(LINE_NUM), TAG_W = 30 − IDX_W.
- IO_SEL, 2'b11: value of Add[17:16] that marks an uncached (I/O) access.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- en  in  1  global enable; 0 freezes all state and suppresses output pulses.
- iLSB_En  in  1  one-cycle request strobe.
- iLSB_Rw  in  1  0 read, 1 write.
- iLSB_Len  in  3  byte count: 1, 2 or 4; naturally aligned.
- iLSB_Add  in  32  byte address.
- iLSB_Dat  in  32  store data, low bytes significant.
- oLSB_En  out  1  one-cycle completion pulse (read data valid, or store acknowledged).
- oLSB_Dat  out  32  read data, zero-extended.
- oMC_En, oMC_Rw, oMC_Len[3], oMC_Add[32], oMC_Dat[32]  out  MC request, same encoding as LSB side; oMC_En is a one-cycle pulse.
- iMC_En  in  1  MC completion pulse, for reads and writes.
- iMC_Dat  in  32  MC read data, zero-extended.
- iROB_Mp  in  1  misprediction flush.

## Operation
- Line: valid bit, TAG_W tag, 32-bit word. Index = Add[IDX_W+1:2], tag = Add[31:IDX_W+2].
- States: IDLE, RD_MISS, RD_IO, WR.
- IDLE, read, cacheable, hit:
  - oLSB_Dat = word >> (8·Add[1:0]), masked to Len bytes.
  - oLSB_En is pulsed next cycle; stay IDLE.
- IDLE, read, cacheable, miss:
  - Issue MC read, Len 4, Add & ~3 → RD_MISS.
  - On iMC_En: write line (valid=1, tag, word), return the extracted bytes → IDLE.
- IDLE, read, Add[17:16]==IO_SEL:
  - Issue MC read with the original Len/Add → RD_IO.
  - On iMC_En: oLSB_Dat = iMC_Dat; no line update → IDLE.
- IDLE, write, any address:
  - Issue MC write with the original Len/Add/Dat → WR.
  - Cacheable hit: merge the Len bytes at Add[1:0] into the line in the same cycle. Miss: line untouched.
  - On iMC_En: pulse oLSB_En → IDLE.
- Requests arriving outside IDLE are ignored. The LSB keeps at most one request outstanding.
- Misprediction:
  - iROB_Mp in RD_MISS/RD_IO: set a kill flag. The MC transaction still completes and RD_MISS still fills the line, but no oLSB_En is produced. The flag clears on return to IDLE.
  - iROB_Mp in IDLE with a read request: the request is discarded; no MC access, no response.
  - iROB_Mp with a write request, or while in WR: the write proceeds normally, including ack.
  - Read hit in flight for the response cycle: the response is suppressed if iROB_Mp is high in that cycle.
- Stores issued under iROB_Mp are accepted even when en=0, matching the committed-store rule.

## Timing
- Reset (rst=0, async): all valid bits 0, state IDLE, kill=0, oLSB_En=0, oLSB_Dat=0, oMC_En=0, oMC_Rw=0, oMC_Len=0, oMC_Add=0, oMC_Dat=0.
- Request at cycle T:
  - Hit response: oLSB_En at T+1.
  - Miss/IO/write: oMC_En at T+1. iMC_En at cycle M ≥ T+2 gives oLSB_En at M+1; the line is filled at the M edge.
- iMC_En while IDLE is ignored.
- Write hit then read of the same word: the read sees the merged data.
- Reset mid-transaction returns to IDLE. A late iMC_En is then ignored.

## Test plan
- Read miss: read 4 @0x100, MC returns 0xDEADBEEF → oMC_En at T+1 (Len 4, Add 0x100); oLSB_Dat=0xDEADBEEF one cycle after iMC_En. Repeating the read gives a hit: oLSB_En at T+1, no oMC_En.
- Byte/half extract and merge: after the fill above, read 1 @0x103 → 0xDE. Write 2 @0x102 data 0x1234 → MC write forwarded; then read 4 @0x100 hit → 0x1234BEEF.
- Aliasing: with LINE_NUM=64, read @0x100 then @0x200 (same index) → second read misses and replaces the line. Re-reading @0x100 misses again.
- IO bypass: read 1 @0x30000 → MC request Len 1, Add 0x30000. Repeating the read issues MC again, with no hit.
- Misprediction: read miss, assert iROB_Mp while waiting → no oLSB_En, but a later read of the same address hits. A write with iROB_Mp=1 in the same cycle → oMC_En=1, Rw=1 at T+1.
- Reset: assert rst=0 in RD_MISS → outputs zero at once; after release, the earlier address misses.
